// File: rtl/boot_pkg.sv
// Shared types and helpers for the post-reset boot loader.
// Holds the top and byte-transfer state encodings plus the command byte selector.
package boot_pkg;

    typedef enum logic [2:0] {
        CMD,
        ADR_H,
        ADR_L,
        RD_HI,
        RD_LO,
        WR,
        DONE,
        ERR
    } boot_state_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_UNLD
    } xfer_state_t;

    localparam logic [7:0] DUMMY_BYTE = 8'h00;

    // Byte shifted out for a given top state; read states clock out the dummy byte.
    function automatic logic [7:0] tx_byte_for(input boot_state_t st,
                                               input logic [7:0]  cmd,
                                               input logic [15:0] ofs);
        logic [7:0] b;
        case (st)
            CMD:     b = cmd;
            ADR_H:   b = ofs[15:8];
            ADR_L:   b = ofs[7:0];
            default: b = DUMMY_BYTE;
        endcase
        return b;
    endfunction

    function automatic logic is_xfer_state(input boot_state_t st);
        return (st == CMD) || (st == ADR_H) || (st == ADR_L) ||
               (st == RD_HI) || (st == RD_LO);
    endfunction

endpackage

// File: rtl/spi_byte_xfer.sv
// Single-byte SPI handshake: load pulse, bounded wait for spi_done, unload pulse.
// Owns the per-byte timeout counter.
module spi_byte_xfer
    import boot_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] tx_byte,
    output logic       spi_load,
    output logic       spi_unload,
    output logic [7:0] spi_din,
    input  logic [7:0] spi_dout,
    input  logic       spi_done,
    output logic [7:0] rx_byte,
    output logic       done,
    output logic       timeout
);

    localparam logic [8:0] TIMEOUT_W = 9'(TIMEOUT);

    xfer_state_t state;
    xfer_state_t state_next;
    logic [7:0]  wait_cnt;
    logic        last_wait;

    // last_wait marks the TIMEOUT-th cycle spent in S_WAIT
    assign last_wait = (({1'b0, wait_cnt} + 9'd1) == TIMEOUT_W);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            wait_cnt <= 8'd0;
        end else begin
            state <= state_next;
            if (state == S_LOAD) begin
                wait_cnt <= 8'd0;
            end else if (state == S_WAIT) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        state_next = state;
        spi_load   = 1'b0;
        spi_unload = 1'b0;
        spi_din    = 8'h00;
        rx_byte    = 8'h00;
        done       = 1'b0;
        timeout    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                spi_load   = 1'b1;
                spi_din    = tx_byte;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                // A done arriving on the final allowed cycle still completes the byte
                if (spi_done) begin
                    state_next = S_UNLD;
                end else if (last_wait) begin
                    timeout    = 1'b1;
                    state_next = S_IDLE;
                end
            end
            S_UNLD: begin
                spi_unload = 1'b1;
                rx_byte    = spi_dout;
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

endmodule

// File: rtl/boot_loader_ctrl.sv
// Boot sequencer: reads WORDS 16-bit words from SPI flash into boot RAM,
// then hands the RAM bus to the CPU and releases its reset.
module boot_loader_ctrl
    import boot_pkg::*;
#(
    parameter int          WORDS     = 16,
    parameter logic [11:0] BASE_ADDR = 12'h000,
    parameter logic [7:0]  FLASH_CMD = 8'h03,
    parameter logic [15:0] FLASH_OFS = 16'h0000,
    parameter int          TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] cpu_addr,
    input  logic [15:0] cpu_dout,
    input  logic        cpu_rdwr,
    input  logic        cpu_en,
    output logic        cpu_rst_n,
    output logic        spi_load,
    output logic        spi_unload,
    output logic [7:0]  spi_din,
    input  logic [7:0]  spi_dout,
    input  logic        spi_done,
    output logic [11:0] mem_addr,
    output logic [15:0] mem_din,
    output logic        mem_we,
    output logic        mem_cs,
    output logic        boot_done,
    output logic        boot_err
);

    localparam logic [11:0] LAST_IDX = 12'(WORDS - 1);

    boot_state_t state;
    boot_state_t state_next;
    logic [11:0] idx;
    logic [7:0]  hi_byte;
    logic [7:0]  lo_byte;
    logic        cpu_rst_q;
    logic        boot_done_q;
    logic        boot_err_q;

    logic        xfer_start;
    logic [7:0]  xfer_tx;
    logic [7:0]  xfer_rx;
    logic        xfer_done;
    logic        xfer_timeout;

    assign xfer_start = is_xfer_state(state);
    assign xfer_tx    = tx_byte_for(state, FLASH_CMD, FLASH_OFS);

    spi_byte_xfer #(
        .TIMEOUT (TIMEOUT)
    ) u_xfer (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (xfer_start),
        .tx_byte    (xfer_tx),
        .spi_load   (spi_load),
        .spi_unload (spi_unload),
        .spi_din    (spi_din),
        .spi_dout   (spi_dout),
        .spi_done   (spi_done),
        .rx_byte    (xfer_rx),
        .done       (xfer_done),
        .timeout    (xfer_timeout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= CMD;
            idx         <= 12'd0;
            hi_byte     <= 8'h00;
            lo_byte     <= 8'h00;
            cpu_rst_q   <= 1'b0;
            boot_done_q <= 1'b0;
            boot_err_q  <= 1'b0;
        end else begin
            state <= state_next;
            if (state == RD_HI && xfer_done) begin
                hi_byte <= xfer_rx;
            end
            if (state == RD_LO && xfer_done) begin
                lo_byte <= xfer_rx;
            end
            if (state == WR) begin
                idx <= idx + 12'd1;
            end
            // Status flags are sticky until the next reset
            cpu_rst_q   <= cpu_rst_q   | (state_next == DONE);
            boot_done_q <= boot_done_q | (state_next == DONE);
            boot_err_q  <= boot_err_q  | (state_next == ERR);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            CMD: begin
                if (xfer_timeout)   state_next = ERR;
                else if (xfer_done) state_next = ADR_H;
            end
            ADR_H: begin
                if (xfer_timeout)   state_next = ERR;
                else if (xfer_done) state_next = ADR_L;
            end
            ADR_L: begin
                if (xfer_timeout)   state_next = ERR;
                else if (xfer_done) state_next = RD_HI;
            end
            RD_HI: begin
                if (xfer_timeout)   state_next = ERR;
                else if (xfer_done) state_next = RD_LO;
            end
            RD_LO: begin
                if (xfer_timeout)   state_next = ERR;
                else if (xfer_done) state_next = WR;
            end
            WR: begin
                state_next = (idx == LAST_IDX) ? DONE : RD_HI;
            end
            DONE:    state_next = DONE;
            ERR:     state_next = ERR;
            default: state_next = ERR;
        endcase
    end

    // The loader owns the RAM bus until DONE; afterwards the CPU drives it directly
    always_comb begin
        mem_addr = 12'h000;
        mem_din  = 16'h0000;
        mem_we   = 1'b0;
        mem_cs   = 1'b0;
        if (state == WR) begin
            mem_addr = BASE_ADDR + idx;
            mem_din  = {hi_byte, lo_byte};
            mem_we   = 1'b1;
            mem_cs   = 1'b1;
        end else if (state == DONE) begin
            mem_addr = cpu_addr;
            mem_din  = cpu_dout;
            mem_we   = cpu_rdwr & cpu_en;
            mem_cs   = cpu_en;
        end
    end

    assign cpu_rst_n = cpu_rst_q;
    assign boot_done = boot_done_q;
    assign boot_err  = boot_err_q;

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Scoreboard bench for boot_loader_ctrl with a behavioural SPI flash model.
// Stimulus pushes expected spi_din bytes and RAM writes; a negedge monitor pops and compares.
module tb_boot_loader_ctrl;

    localparam int          WORDS     = 2;
    localparam int          TIMEOUT   = 20;
    localparam logic [11:0] BASE_ADDR = 12'hFFF;
    localparam logic [7:0]  FLASH_CMD = 8'h03;
    localparam logic [15:0] FLASH_OFS = 16'h0120;
    localparam int          NORM_DLY  = 8;

    logic        clk;
    logic        rst_n;
    logic [11:0] cpu_addr;
    logic [15:0] cpu_dout;
    logic        cpu_rdwr;
    logic        cpu_en;
    logic        cpu_rst_n;
    logic        spi_load;
    logic        spi_unload;
    logic [7:0]  spi_din;
    logic [7:0]  spi_dout;
    logic        spi_done;
    logic        model_done;
    logic        stray_done;
    logic [11:0] mem_addr;
    logic [15:0] mem_din;
    logic        mem_we;
    logic        mem_cs;
    logic        boot_done;
    logic        boot_err;

    assign spi_done = model_done | stray_done;

    boot_loader_ctrl #(
        .WORDS     (WORDS),
        .BASE_ADDR (BASE_ADDR),
        .FLASH_CMD (FLASH_CMD),
        .FLASH_OFS (FLASH_OFS),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_addr   (cpu_addr),
        .cpu_dout   (cpu_dout),
        .cpu_rdwr   (cpu_rdwr),
        .cpu_en     (cpu_en),
        .cpu_rst_n  (cpu_rst_n),
        .spi_load   (spi_load),
        .spi_unload (spi_unload),
        .spi_din    (spi_din),
        .spi_dout   (spi_dout),
        .spi_done   (spi_done),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_we     (mem_we),
        .mem_cs     (mem_cs),
        .boot_done  (boot_done),
        .boot_err   (boot_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int fails  = 0;

    logic [7:0]  exp_din_q[$];
    logic [27:0] exp_wr_q[$];

    int load_cnt   = 0;
    int unload_cnt = 0;
    int write_cnt  = 0;
    int load_cyc   = 0;
    int wr_cyc     = 0;

    int drop_idx = -1;
    int late_idx = -1;
    logic [7:0] flash [4];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // SPI flash model: spi_done NORM_DLY cycles after each load, with per-load overrides
    initial begin
        int idx;
        int dly;
        logic [7:0] data;
        idx        = 0;
        model_done = 1'b0;
        spi_dout   = 8'h00;
        flash[0] = 8'h12; flash[1] = 8'h34; flash[2] = 8'hAB; flash[3] = 8'hCD;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                idx = 0;
            end else if (spi_load) begin
                dly  = (idx == drop_idx) ? 0 : (idx == late_idx) ? TIMEOUT : NORM_DLY;
                data = (idx < 3) ? 8'hEE : flash[(idx - 3) % 4];
                idx++;
                if (dly > 0) begin
                    @(posedge clk);
                    repeat (dly - 1) @(posedge clk);
                    #1 model_done = 1'b1;
                    spi_dout = data;
                    @(posedge clk);
                    #1 model_done = 1'b0;
                end
            end
        end
    end

    // Monitor: compares every spi_load byte and every loader-owned RAM access
    always @(negedge clk) begin
        logic [27:0] e;
        if (rst_n) begin
            if (spi_load) begin
                load_cnt++;
                load_cyc = cyc;
                if (exp_din_q.size() == 0) checkOutput("spi_load_unexpected", 32'(spi_load), 32'd0);
                else checkOutput("spi_din", 32'(spi_din), 32'(exp_din_q.pop_front()));
            end
            if (spi_unload) unload_cnt++;
            if (!boot_done && (mem_cs || mem_we)) begin
                write_cnt++;
                wr_cyc = cyc;
                if (exp_wr_q.size() == 0) checkOutput("mem_write_unexpected", 32'(mem_we), 32'd0);
                else begin
                    e = exp_wr_q.pop_front();
                    checkOutput("mem_write", {2'b00, mem_cs, mem_we, mem_addr, mem_din}, {4'b0011, e});
                end
            end
        end
    end

    task automatic pushBootExpect(input bit full);
        logic [11:0] a;
        exp_din_q.push_back(FLASH_CMD);
        exp_din_q.push_back(8'h01);
        exp_din_q.push_back(8'h20);
        if (full) begin
            for (int w = 0; w < WORDS; w++) begin
                exp_din_q.push_back(8'h00);
                exp_din_q.push_back(8'h00);
                a = BASE_ADDR + 12'(w);
                exp_wr_q.push_back({a, flash[2*w], flash[2*w+1]});
            end
        end
    endtask

    task automatic checkReset();
        checkOutput("rst_cpu_rst_n",  32'(cpu_rst_n),  32'd0);
        checkOutput("rst_spi_load",   32'(spi_load),   32'd0);
        checkOutput("rst_spi_unload", 32'(spi_unload), 32'd0);
        checkOutput("rst_spi_din",    32'(spi_din),    32'd0);
        checkOutput("rst_mem_we",     32'(mem_we),     32'd0);
        checkOutput("rst_mem_cs",     32'(mem_cs),     32'd0);
        checkOutput("rst_boot_done",  32'(boot_done),  32'd0);
        checkOutput("rst_boot_err",   32'(boot_err),   32'd0);
    endtask

    task automatic applyReset();
        @(negedge clk);
        rst_n = 1'b0;
        exp_din_q.delete();
        exp_wr_q.delete();
        repeat (12) @(negedge clk);
    endtask

    task automatic applyStimulus(input bit full);
        pushBootExpect(full);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic waitDone(input int budget);
        int n = 0;
        while (!boot_done && !boot_err && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) checkOutput("wait_done_bound", 32'(boot_done), 32'd1);
    endtask

    task automatic waitLoads(input int base, input int target, input int budget);
        int n = 0;
        while ((load_cnt - base) < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) checkOutput("wait_loads_bound", 32'(load_cnt - base), 32'(target));
    endtask

    initial begin
        int bl, bu, bw, n, done_cyc, lc;
        rst_n = 1'b0; cpu_addr = 12'h000; cpu_dout = 16'h0000;
        cpu_rdwr = 1'b0; cpu_en = 1'b0; stray_done = 1'b0;
        repeat (3) @(negedge clk);
        checkReset();

        // Normal boot: 3 discarded bytes, two words written across the address wrap
        bu = unload_cnt; bw = write_cnt;
        applyStimulus(1'b1);
        n = 0;
        while (!mem_we && n < 400) begin @(negedge clk); n++; end
        checkOutput("unloads_before_first_write", 32'(unload_cnt - bu), 32'd5);
        waitDone(400);
        done_cyc = cyc;
        checkOutput("cpu_rst_n_after_boot", 32'(cpu_rst_n), 32'd1);
        checkOutput("boot_done_after_boot", 32'(boot_done), 32'd1);
        checkOutput("boot_err_after_boot",  32'(boot_err),  32'd0);
        checkOutput("release_cycle", 32'(done_cyc), 32'(wr_cyc + 1));
        checkOutput("total_unloads", 32'(unload_cnt - bu), 32'd7);
        checkOutput("total_writes",  32'(write_cnt - bw),  32'd2);
        checkOutput("din_queue_empty", 32'(exp_din_q.size()), 32'd0);

        // CPU pass-through in DONE
        cpu_addr = 12'h007; cpu_dout = 16'hBEEF; cpu_en = 1'b1; cpu_rdwr = 1'b1;
        #1;
        checkOutput("pass_addr", 32'(mem_addr), 32'h007);
        checkOutput("pass_din",  32'(mem_din),  32'hBEEF);
        checkOutput("pass_we",   32'(mem_we),   32'd1);
        checkOutput("pass_cs",   32'(mem_cs),   32'd1);
        cpu_rdwr = 1'b0; #1;
        checkOutput("pass_read_we", 32'(mem_we), 32'd0);
        cpu_en = 1'b0; #1;
        checkOutput("pass_idle_cs", 32'(mem_cs), 32'd0);

        // Stray spi_done pulses after DONE must not start a transfer
        bl = load_cnt; bu = unload_cnt;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); stray_done = 1'b1;
            @(negedge clk); stray_done = 1'b0;
        end
        repeat (5) @(negedge clk);
        checkOutput("stray_loads",   32'(load_cnt - bl),   32'd0);
        checkOutput("stray_unloads", 32'(unload_cnt - bu), 32'd0);
        checkOutput("stray_boot_done", 32'(boot_done), 32'd1);

        // Reset during word 1 RD_LO, with CPU bus noise that must be ignored while booting
        applyReset();
        cpu_addr = 12'hFFF; cpu_dout = 16'h5555; cpu_en = 1'b1; cpu_rdwr = 1'b1;
        bl = load_cnt; bw = write_cnt;
        applyStimulus(1'b1);
        waitLoads(bl, 7, 400);
        checkOutput("writes_before_abort", 32'(write_cnt - bw), 32'd1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 checkReset();
        exp_din_q.delete();
        exp_wr_q.delete();
        repeat (12) @(negedge clk);
        bw = write_cnt;
        applyStimulus(1'b1);
        waitDone(400);
        checkOutput("reload_writes", 32'(write_cnt - bw), 32'd2);
        checkOutput("reload_boot_done", 32'(boot_done), 32'd1);
        cpu_en = 1'b0; cpu_rdwr = 1'b0;

        // Timeout: flash never answers the ADR_L byte
        applyReset();
        drop_idx = 2;
        bl = load_cnt; bw = write_cnt;
        applyStimulus(1'b0);
        waitLoads(bl, 3, 200);
        lc = load_cyc;
        n = 0;
        while (!boot_err && n < TIMEOUT + 40) begin @(negedge clk); n++; end
        checkOutput("err_cycle", 32'(cyc), 32'(lc + 1 + TIMEOUT));
        checkOutput("err_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        checkOutput("err_boot_done", 32'(boot_done), 32'd0);
        repeat (30) @(negedge clk);
        checkOutput("err_sticky",  32'(boot_err), 32'd1);
        checkOutput("err_loads",   32'(load_cnt - bl),  32'd3);
        checkOutput("err_writes",  32'(write_cnt - bw), 32'd0);
        drop_idx = -1;

        // spi_done on the last allowed wait cycle still completes the byte
        applyReset();
        late_idx = 3;
        bw = write_cnt;
        applyStimulus(1'b1);
        waitDone(600);
        checkOutput("late_boot_err",  32'(boot_err),  32'd0);
        checkOutput("late_boot_done", 32'(boot_done), 32'd1);
        checkOutput("late_writes", 32'(write_cnt - bw), 32'd2);
        checkOutput("wr_queue_empty", 32'(exp_wr_q.size()), 32'd0);
        late_idx = -1;

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/boot_loader_ctrl.md
Name: boot_loader_ctrl

Overview:
Post-reset boot sequencer for the SoC memory/IO bus. It holds the CPU in reset and drives the spi block with a flash read command. It assembles the returned bytes into 16-bit words and writes them into the boot RAM. It then hands the RAM bus to the CPU and releases the CPU reset.

Parameters:
WORDS, 16, number of 16-bit words loaded (1..4096)
BASE_ADDR, 12'h000, first RAM word address written
FLASH_CMD, 8'h03, flash read opcode sent first
FLASH_OFS, 16'h0000, flash byte offset, sent MSB first after opcode
TIMEOUT, 255, max cycles waiting for spi_done per byte (8-bit counter)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
cpu_addr  in  12  CPU bus address
cpu_dout  in  16  CPU write data
cpu_rdwr  in  1  CPU write strobe (1=write)
cpu_en  in  1  CPU bus enable
cpu_rst_n  out  1  CPU reset, low while booting
spi_load  out  1  1-cycle pulse: load spi_din into spi shifter
spi_unload  out  1  1-cycle pulse: read spi_dout
spi_din  out  8  byte to transmit
spi_dout  in  8  byte received
spi_done  in  1  1-cycle pulse: byte shift complete
mem_addr  out  12  RAM address
mem_din  out  16  RAM write data
mem_we  out  1  RAM write enable
mem_cs  out  1  RAM chip select
boot_done  out  1  sticky, load finished
boot_err  out  1  sticky, spi timeout

Behaviour:
- Reset values: cpu_rst_n=0, spi_load=0, spi_unload=0, spi_din=0, mem_we=0, mem_cs=0, boot_done=0, boot_err=0, word index=0, FSM=CMD.
- Reset mid-operation aborts everything. Boot restarts from CMD after rst_n deasserts.
- Top FSM:
  - CMD sends FLASH_CMD, then goes to ADR_H.
  - ADR_H sends FLASH_OFS[15:8], then goes to ADR_L.
  - ADR_L sends FLASH_OFS[7:0], then goes to RD_HI.
  - RD_HI sends 8'h00 and captures the high byte, then goes to RD_LO.
  - RD_LO sends 8'h00 and captures the low byte, then goes to WR.
  - WR lasts 1 cycle, then goes to RD_HI, or to DONE when index==WORDS-1.
  - Any byte timeout goes to ERR. DONE and ERR are terminal.
- Byte transfer, identical for every byte:
  - S_LOAD, 1 cycle: spi_load=1, spi_din=byte.
  - S_WAIT: timeout counter increments each cycle.
  - In S_WAIT, spi_done=1 goes to S_UNLD. Counter==TIMEOUT without spi_done goes to ERR. If spi_done arrives in the cycle the counter reaches TIMEOUT, spi_done wins.
  - S_UNLD, 1 cycle: spi_unload=1, spi_dout captured at end of cycle. The byte is discarded for CMD/ADR states.
  - spi_done outside S_WAIT is ignored.
  - The counter clears at each S_LOAD.
- Byte latency: 2 + (cycles from S_LOAD exit to spi_done sampled) + 1.
- WR cycle:
  - mem_cs=1, mem_we=1, mem_addr=BASE_ADDR+index (12-bit, wraps mod 4096), mem_din={hi,lo}.
  - index increments after the write.
- DONE:
  - cpu_rst_n=1 and boot_done=1 from the first cycle after WR, both registered.
  - From then on mem_addr=cpu_addr, mem_din=cpu_dout, mem_we=cpu_rdwr&cpu_en, mem_cs=cpu_en (combinational pass-through).
- ERR:
  - boot_err=1, cpu_rst_n stays 0, mem_cs=mem_we=0, spi pulses stay 0.
  - Held until rst_n.
- While booting, CPU bus inputs are ignored and mem_* are driven only by the loader.
- mem_cs/mem_we are 0 in all states other than WR and DONE.

Decomposition:
- Package boot_pkg: top FSM state enum (CMD, ADR_H, ADR_L, RD_HI, RD_LO, WR, DONE, ERR), byte FSM enum (S_IDLE, S_LOAD, S_WAIT, S_UNLD), DUMMY_BYTE=8'h00.
- One sub-module, spi_byte_xfer: start/byte in; spi_load, spi_unload, spi_din, rx_byte, done and timeout out; owns the timeout counter.

Test Plan:
- spi model answers spi_done 8 cycles after each load; flash bytes 12 34 AB CD; WORDS=2 -> exactly 3 discard unloads, then RAM[0]=16'h1234 and RAM[1]=16'hABCD. Both writes are single cycles with we=1. cpu_rst_n rises the cycle after the 2nd write; boot_done=1.
- spi_din sequence check, FLASH_OFS=16'h0120 -> spi_din at successive spi_load pulses = 03,01,20,00,00,...
- spi_done never asserted during ADR_L -> boot_err=1 exactly TIMEOUT cycles after the ADR_L S_WAIT entry. cpu_rst_n stays 0; no mem_we seen.
- spi_done coincident with counter==TIMEOUT -> transfer proceeds; boot_err stays 0.
- rst_n pulsed low during word 1 RD_LO -> all outputs at reset values asynchronously. After release, a full reload starts with FLASH_CMD; RAM[0] is rewritten.
- After DONE, CPU writes 16'hBEEF at 12'h007 with cpu_en=1, cpu_rdwr=1 -> mem_addr=007, mem_din=BEEF, mem_we=1 in the same cycle. Stray spi_done pulses cause no spi_load/spi_unload.
